sync_req_arbiter: RTL
=====================

Name: sync_req_arbiter

Overview:
- Round-robin arbiter that shares one single-clock resource between NUM_REQ requesters living in foreign or asynchronous clock domains.
- Each requester uses a 4-phase req/ack handshake on level signals.
- Requests are synchronized internally. Acks are driven as registered levels, so the far side can synchronize them with its own flop chain.
- Sits between CPU-bus/UART-side request logic and a shared local engine, e.g. a memory port or config register file.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SYNC_STAGES, 2, flip-flop depth of each request synchronizer (>=2).
- TIMEOUT_CYCLES, 1024, watchdog limit in clocks; used only with the optional feature.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_async  in  NUM_REQ  per-requester level request; asynchronous to clock.
- ack  out  NUM_REQ  per-requester registered acknowledge level.
- res_start  out  1  one-cycle pulse launching a resource operation.
- res_sel  out  SEL_W  index of the granted requester; SEL_W = max(1, clog2(NUM_REQ)).
- grant  out  NUM_REQ  one-hot granted requester; all-zero when idle.
- res_done  in  1  one-cycle pulse from the resource: operation complete.
- busy  out  1  high in any state other than IDLE.
- res_abort  out  1  one-cycle abort pulse to the resource (optional feature only; tied 0 otherwise).
- err_timeout  out  1  sticky timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: ack=0, res_start=0, res_sel=0, grant=0, busy=0, res_abort=0, err_timeout=0, state=IDLE, rr_ptr=NUM_REQ-1.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values. Requester ack drops asynchronously.
- Synchronization:
  - req_sync[i] is req_async[i] delayed through SYNC_STAGES flops.
  - Synchronizer flops reset to 0.
- Arbitration (IDLE):
  - Candidates are req_sync[i]=1.
  - Winner is the first candidate searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - On a winner: next cycle state=START, grant[w]=1, res_sel=w.
- START (1 cycle): res_start=1.
  - If res_done=1 in this cycle, go to ACK; otherwise go to BUSY.
- BUSY: hold grant and res_sel; on res_done=1 go to ACK.
- ACK:
  - ack[w]=1, grant held.
  - Wait for req_sync[w]=0, then next cycle: ack[w]=0, grant=0, rr_ptr=w, state=IDLE.
- res_done outside START/BUSY is ignored.
- A requester dropping req before ack has no effect. The operation completes and ack is raised and dropped once req_sync is low.
- Only one ack bit is ever high; ack bits are glitch-free register outputs.
- Latency, from the first clock edge sampling req_async high with the arbiter IDLE:
  - res_start rises after SYNC_STAGES+1 edges.
  - ack rises 1 edge after res_done is sampled.
- A request arriving while busy waits; the rr_ptr update guarantees each waiting requester is served within NUM_REQ grants.

Optional Feature:
- Macro SYNC_REQ_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering START and increments in START/BUSY.
  - On reaching TIMEOUT_CYCLES-1 without res_done: pulse res_abort for 1 cycle, set err_timeout, and go to ACK (the requester still completes its handshake).
  - err_timeout clears only on reset.
- Undefined: no counter; res_abort and err_timeout are constant 0.

Decomposition:
- Package sync_req_arbiter_pkg holds:
  - state encoding typedef (IDLE, START, BUSY, ACK);
  - function clog2_min1 for SEL_W;
  - default-timeout constant.
- Sub-module req_sync_chain is a parameterized SYNC_STAGES-deep reset-to-0 flop chain, one instance per requester (generate loop).

Test Plan:
- Single request: req_async[2]=1, res_done 3 clocks after res_start -> res_start at edge SYNC_STAGES+1, res_sel=2, grant=4'b0100; ack[2]=1 the edge after res_done; ack[2]=0 SYNC_STAGES+1 edges after req drops.
- Simultaneous req_async=4'b1111 from reset, each re-raised after its ack falls -> grant order 0,1,2,3,0; never two ack bits high.
- res_done in the START cycle -> BUSY skipped, ack high next edge. Stray res_done while IDLE -> no state change.
- Assert rst_n=0 during BUSY with grant=4'b0010 -> ack, grant, busy, res_start all 0 immediately; after release the first winner is requester 0.
- With SYNC_REQ_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no res_done -> res_abort pulse 16 cycles after res_start, err_timeout=1 and sticky, ack raised; without the macro the arbiter stays in BUSY indefinitely.

Source files
------------

// File: rtl/sync_req_arbiter_pkg.sv
// Shared types and helpers for the synchronizing round-robin request arbiter.
package sync_req_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        ACK   = 2'd3
    } state_e;

    // Watchdog limit used when the timeout build option is enabled.
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/req_sync_chain.sv
// Single-bit level synchronizer: STAGES flops in series, all reset to 0.
module req_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value on the same edge.
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter granting one shared local resource to NUM_REQ requesters
// that talk a 4-phase req/ack level handshake from foreign clock domains.
// Requests are synchronized internally; acks are registered levels.
// Build option: define SYNC_REQ_ARBITER_TIMEOUT_EN to add a watchdog that
// aborts a resource operation lasting TIMEOUT_CYCLES clocks.
module sync_req_arbiter
    import sync_req_arbiter_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  SYNC_STAGES    = 2,
    parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int SEL_W          = clog2_min1(NUM_REQ)
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_async,
    output logic [NUM_REQ-1:0] ack,
    output logic               res_start,
    output logic [SEL_W-1:0]   res_sel,
    output logic [NUM_REQ-1:0] grant,
    input  logic               res_done,
    output logic               busy,
    output logic               res_abort,
    output logic               err_timeout
);

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("sync_req_arbiter: NUM_REQ must be in 2..8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("sync_req_arbiter: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("sync_req_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    state_e             state_q;
    logic [SEL_W-1:0]   rr_ptr_q;
    logic [SEL_W-1:0]   sel_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               res_start_q;

    logic [NUM_REQ-1:0] req_sync;
    logic               hi_found;
    logic               lo_found;
    logic [SEL_W-1:0]   hi_idx;
    logic [SEL_W-1:0]   lo_idx;
    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic               timeout_hit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
        req_sync_chain #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clock(clock),
            .rst_n(rst_n),
            .d_i  (req_async[i]),
            .q_o  (req_sync[i])
        );
    end

    // Round-robin pick: lowest requester above rr_ptr, else lowest at or below it.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_sync[i]) begin
                if (i > int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_W'(i);
                end
            end
        end
        win_found = hi_found | lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Arbitration FSM with registered grant, select, start pulse and ack.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= SEL_W'(NUM_REQ - 1);
            sel_q       <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            res_start_q <= 1'b0;
        end else begin
            res_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q     <= START;
                        sel_q       <= win_idx;
                        grant_q     <= NUM_REQ'(1) << win_idx;
                        res_start_q <= 1'b1;
                    end
                end
                START, BUSY: begin
                    if (res_done || timeout_hit) begin
                        state_q <= ACK;
                        ack_q   <= grant_q;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                ACK: begin
                    if (!req_sync[sel_q]) begin
                        state_q  <= IDLE;
                        ack_q    <= '0;
                        grant_q  <= '0;
                        rr_ptr_q <= sel_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SYNC_REQ_ARBITER_TIMEOUT_EN
    localparam int               CNT_W    = clog2_min1(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             res_abort_q;
    logic             err_timeout_q;

    // A res_done arriving on the final count still completes normally.
    assign timeout_hit = ((state_q == START) || (state_q == BUSY)) && !res_done
                         && (tmo_cnt_q == CNT_LAST);

    // Watchdog counter, abort pulse and sticky timeout flag.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            res_abort_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            res_abort_q <= timeout_hit;
            if (timeout_hit) begin
                err_timeout_q <= 1'b1;
            end
            if (state_q == IDLE && win_found) begin
                tmo_cnt_q <= '0;
            end else if (state_q == START || state_q == BUSY) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
        end
    end

    assign res_abort   = res_abort_q;
    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign res_abort   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign ack       = ack_q;
    assign grant     = grant_q;
    assign res_sel   = sel_q;
    assign res_start = res_start_q;
    assign busy      = (state_q != IDLE);

endmodule
